bpu_gshare: RTL and testbench
=============================

# bpu_gshare

Parametrised dual-slot branch predictor for the two-wide fetch front end. It uses a tagged BTB (valid/tag/target) and a separate 2-bit counter PHT indexed by PC hash XOR global history (gshare). The block predicts the two fetch slots at `if_pc` and `if_pc+4` combinationally. It also resolves two execute slots per cycle, drives the pipeline flush, and keeps hit/miss performance counters.

## Interface
- `IDX_W`, 10, BTB/PHT index width; depth = 2^IDX_W; legal 4..14
- `TAG_W`, 8, tag width; tag = pc[31:32-TAG_W]
- `GHR_W`, 8, global history length; 0 = pure bimodal, legal 0..IDX_W
- `CTR_INIT`, 2'b10, counter value at reset and on allocation
- `cpu_clk`  in  1  clock, rising edge
- `cpu_rstn`  in  1  reset, asynchronous, active-low
- `if_pc`  in  32  fetch PC, slot0 = if_pc, slot1 = if_pc+4
- `pred_taken1`  out  1  slot0 predicted taken
- `pred_taken2`  out  1  slot1 predicted taken (only when slot0 not taken)
- `pred_addr`  out  32  next fetch PC
- `bpu_flush`  out  1  resolved target mismatch, flush younger instructions
- `bpu_clear`  in  1  synchronous invalidate of all BTB entries and GHR
- `ex_valid1/2`, `ex_is_bj_1/2`, `real_taken1/2`  in  1 each  resolve slot valid, is branch/jump, actual direction
- `ex_pc_1/2`, `real_addr1/2`, `pred_addr1/2`  in  32 each  branch PC, actual next PC, next PC predicted at fetch
- `perf_br_cnt`, `perf_miss_cnt`  out  32 each  resolved branches, mispredicts

## Operation
- Hash: idx(pc) = pc[IDX_W+1:2] ^ pc[2*IDX_W+1:IDX_W+2]. phtidx(pc) = idx(pc) ^ zero-extended GHR (idx(pc) when GHR_W=0).
- Hit_k = valid[idx] & tag[idx]==pc tag. t_k = hit_k & pht[phtidx][1].
- pred_taken1 = t0. pred_taken2 = t1 & !t0.
- pred_addr = t0 ? btb_tgt[idx0] : t1 ? btb_tgt[idx1] : if_pc+8 (mod 2^32).
- err1 = ex_valid1 & pred_addr1!=real_addr1.
- Slot2 is live when ex_valid2 & !err1 & !(ex_valid1 & ex_is_bj_1 & real_taken1).
- err2 = live2 & pred_addr2!=real_addr2.
- bpu_flush = err1 | err2. A wrong direction with a correct target is not an error.
- Per live resolving branch (slot1: ex_valid1 & ex_is_bj_1; slot2: live2 & ex_is_bj_2):
  - BTB hit: PHT counter saturating inc if taken, dec if not. If taken, target <= real_addr.
  - BTB miss and taken: allocate or replace; valid=1, tag, target=real_addr, pht[phtidx]=CTR_INIT.
  - BTB miss and not taken: no BTB/PHT change.
- Same-cycle conflicts: when both slots hit the same BTB index or the same PHT index, slot1 writes and slot2's write to that structure is dropped.
- GHR: each resolving branch shifts its real_taken in at LSB, slot1 then slot2 (two bits per cycle if both resolve). All index computations in a cycle use the pre-update GHR.
- Perf: perf_br_cnt += number of resolving branches (0..2). perf_miss_cnt += err1+err2. Both wrap modulo 2^32.
- bpu_clear: next edge clears all valid and GHR. Counters, targets and perf are untouched. Clear overrides same-cycle updates and allocations; flush/perf still reflect that cycle.

## Timing
- Prediction is purely combinational from if_pc: zero-cycle latency.
- Updates are registered on the rising cpu_clk. A read in the same cycle as a write to that entry returns the old value; the new value is visible the next cycle.
- bpu_flush is combinational from the resolve inputs in the same cycle, not registered.
- Reset (async assert, any cycle, including mid-update):
  - valid = 0, PHT = CTR_INIT, GHR = 0, perf counters = 0.
  - Hence pred_taken1/2 = 0 and pred_addr = if_pc+8.
- Tag and target arrays are not reset.
- Counter saturation: 2'b11 stays on taken, 2'b00 stays on not-taken.

## Test plan
- Reset, if_pc=0x1C000000 -> pred_taken1=0, pred_taken2=0, pred_addr=0x1C000008, perf counters 0.
- Resolve slot1 pc=0x1C000010, taken, real=0x1C000100, pred=0x1C000018 -> bpu_flush=1, perf_miss_cnt=1. Next cycle with GHR adjusted back to lookup state (GHR_W=0 build) and if_pc=0x1C000010 -> pred_taken1=1, pred_addr=0x1C000100.
- GHR_W=0 build, same branch resolved not-taken twice -> counter 2->1->0. Then fetch at 0x1C00000C -> pred_taken2=0, pred_addr=0x1C000014. Three takens from 0 -> 3, fourth keeps 3.
- Slot1 taken-correct plus slot2 branch with mismatched pred_addr2 in the same cycle -> slot2 not live: bpu_flush=0, perf_br_cnt +1, slot2 BTB unchanged.
- Two pcs aliasing to one index, both allocating in the same cycle -> slot1's tag/target stored. Then bpu_clear -> all predictions not-taken next cycle, perf counters unchanged.
- Assert cpu_rstn low mid-stream with pending allocations -> all valid clear and perf=0 immediately (async); no partial write survives.

Source files
------------

// File: rtl/bpu_gshare_if.sv
// Fetch/resolve bus between the two-wide front end and the gshare predictor.
// The pipeline side drives the master modport; bpu_gshare takes the slave modport.
interface bpu_gshare_if;
  logic [31:0] if_pc;
  logic        pred_taken1;
  logic        pred_taken2;
  logic [31:0] pred_addr;
  logic        bpu_flush;
  logic        bpu_clear;
  logic        ex_valid1;
  logic        ex_valid2;
  logic        ex_is_bj_1;
  logic        ex_is_bj_2;
  logic        real_taken1;
  logic        real_taken2;
  logic [31:0] ex_pc_1;
  logic [31:0] ex_pc_2;
  logic [31:0] real_addr1;
  logic [31:0] real_addr2;
  logic [31:0] pred_addr1;
  logic [31:0] pred_addr2;
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_miss_cnt;

  modport master (
    output if_pc, bpu_clear,
    output ex_valid1, ex_valid2, ex_is_bj_1, ex_is_bj_2, real_taken1, real_taken2,
    output ex_pc_1, ex_pc_2, real_addr1, real_addr2, pred_addr1, pred_addr2,
    input  pred_taken1, pred_taken2, pred_addr, bpu_flush, perf_br_cnt, perf_miss_cnt
  );

  modport slave (
    input  if_pc, bpu_clear,
    input  ex_valid1, ex_valid2, ex_is_bj_1, ex_is_bj_2, real_taken1, real_taken2,
    input  ex_pc_1, ex_pc_2, real_addr1, real_addr2, pred_addr1, pred_addr2,
    output pred_taken1, pred_taken2, pred_addr, bpu_flush, perf_br_cnt, perf_miss_cnt
  );
endinterface

// File: rtl/bpu_gshare.sv
// Dual-slot gshare branch predictor: tagged BTB plus 2-bit PHT, combinational
// two-slot lookup, two-slot resolve with flush generation and perf counters.
module bpu_gshare #(
  parameter int         IDX_W    = 10,
  parameter int         TAG_W    = 8,
  parameter int         GHR_W    = 8,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input logic         cpu_clk,
  input logic         cpu_rstn,
  bpu_gshare_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [31:0]      r_tgt [DEPTH];
  logic [1:0]       r_pht [DEPTH];
  logic [31:0]      r_perf_br;
  logic [31:0]      r_perf_miss;

  logic [IDX_W-1:0] w_ghr_x;
  logic [31:0]      w_pc1;
  logic [IDX_W-1:0] w_bi0, w_bi1, w_pi0, w_pi1;
  logic             w_hit0, w_hit1, w_t0, w_t1;

  logic             w_err1, w_err2, w_live2, w_res1, w_res2;
  logic [IDX_W-1:0] w_rb1, w_rb2, w_rp1, w_rp2;
  logic             w_rh1, w_rh2;
  logic             w_bwe1, w_bwe2, w_pwe1, w_pwe2;
  logic [1:0]       w_pn1, w_pn2;
  logic             w_unused;

  function automatic logic [IDX_W-1:0] f_idx(input logic [31:0] pc);
    return pc[IDX_W+1:2] ^ pc[2*IDX_W+1:IDX_W+2];
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [31:0] pc);
    return pc[31:32-TAG_W];
  endfunction

  function automatic logic [1:0] f_sat(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Only parts of each PC feed the hash/tag; the rest is deliberately ignored.
  assign w_unused = ^{bus.if_pc, bus.ex_pc_1, bus.ex_pc_2};

  // Fetch-side lookup for slot0 (if_pc) and slot1 (if_pc+4)
  assign w_pc1  = bus.if_pc + 32'd4;
  assign w_bi0  = f_idx(bus.if_pc);
  assign w_bi1  = f_idx(w_pc1);
  assign w_pi0  = w_bi0 ^ w_ghr_x;
  assign w_pi1  = w_bi1 ^ w_ghr_x;
  assign w_hit0 = r_valid[w_bi0] && (r_tag[w_bi0] == f_tag(bus.if_pc));
  assign w_hit1 = r_valid[w_bi1] && (r_tag[w_bi1] == f_tag(w_pc1));
  assign w_t0   = w_hit0 && r_pht[w_pi0][1];
  assign w_t1   = w_hit1 && r_pht[w_pi1][1];

  assign bus.pred_taken1 = w_t0;
  assign bus.pred_taken2 = w_t1 && !w_t0;
  assign bus.pred_addr   = w_t0 ? r_tgt[w_bi0] :
                           w_t1 ? r_tgt[w_bi1] : bus.if_pc + 32'd8;

  // Slot2 is dead behind a slot1 redirect or a taken slot1 branch
  assign w_err1  = bus.ex_valid1 && (bus.pred_addr1 != bus.real_addr1);
  assign w_live2 = bus.ex_valid2 && !w_err1 &&
                   !(bus.ex_valid1 && bus.ex_is_bj_1 && bus.real_taken1);
  assign w_err2  = w_live2 && (bus.pred_addr2 != bus.real_addr2);
  assign w_res1  = bus.ex_valid1 && bus.ex_is_bj_1;
  assign w_res2  = w_live2 && bus.ex_is_bj_2;

  assign bus.bpu_flush = w_err1 || w_err2;

  assign w_rb1 = f_idx(bus.ex_pc_1);
  assign w_rb2 = f_idx(bus.ex_pc_2);
  assign w_rp1 = w_rb1 ^ w_ghr_x;
  assign w_rp2 = w_rb2 ^ w_ghr_x;
  assign w_rh1 = r_valid[w_rb1] && (r_tag[w_rb1] == f_tag(bus.ex_pc_1));
  assign w_rh2 = r_valid[w_rb2] && (r_tag[w_rb2] == f_tag(bus.ex_pc_2));

  // A taken branch always (re)writes its BTB entry; on a hit tag/valid are unchanged.
  assign w_bwe1 = w_res1 && bus.real_taken1;
  assign w_bwe2 = w_res2 && bus.real_taken2 && !(w_res1 && (w_rb1 == w_rb2));
  assign w_pwe1 = w_res1 && (w_rh1 || bus.real_taken1);
  assign w_pwe2 = w_res2 && (w_rh2 || bus.real_taken2) && !(w_res1 && (w_rp1 == w_rp2));
  assign w_pn1  = w_rh1 ? f_sat(r_pht[w_rp1], bus.real_taken1) : CTR_INIT;
  assign w_pn2  = w_rh2 ? f_sat(r_pht[w_rp2], bus.real_taken2) : CTR_INIT;

  generate
    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] r_ghr;
      logic [GHR_W-1:0] w_ghr_nxt;

      always_comb begin
        w_ghr_nxt = r_ghr;
        if (w_res1) w_ghr_nxt = (w_ghr_nxt << 1) | GHR_W'(bus.real_taken1);
        if (w_res2) w_ghr_nxt = (w_ghr_nxt << 1) | GHR_W'(bus.real_taken2);
      end

      always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn)          r_ghr <= '0;
        else if (bus.bpu_clear) r_ghr <= '0;
        else                    r_ghr <= w_ghr_nxt;
      end

      assign w_ghr_x = IDX_W'(r_ghr);
    end else begin : g_bimodal
      assign w_ghr_x = '0;
    end
  endgenerate

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_pht[i] <= CTR_INIT;
    end else if (bus.bpu_clear) begin
      r_valid <= '0;
    end else begin
      if (w_bwe1) r_valid[w_rb1] <= 1'b1;
      if (w_bwe2) r_valid[w_rb2] <= 1'b1;
      if (w_pwe1) r_pht[w_rp1]   <= w_pn1;
      if (w_pwe2) r_pht[w_rp2]   <= w_pn2;
    end
  end

  // Tag/target payload is never reset; valid alone qualifies it.
  always_ff @(posedge cpu_clk) begin
    if (!bus.bpu_clear) begin
      if (w_bwe1) begin
        r_tag[w_rb1] <= f_tag(bus.ex_pc_1);
        r_tgt[w_rb1] <= bus.real_addr1;
      end
      if (w_bwe2) begin
        r_tag[w_rb2] <= f_tag(bus.ex_pc_2);
        r_tgt[w_rb2] <= bus.real_addr2;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_perf_br   <= '0;
      r_perf_miss <= '0;
    end else begin
      r_perf_br   <= r_perf_br + {31'd0, w_res1} + {31'd0, w_res2};
      r_perf_miss <= r_perf_miss + {31'd0, w_err1} + {31'd0, w_err2};
    end
  end

  assign bus.perf_br_cnt   = r_perf_br;
  assign bus.perf_miss_cnt = r_perf_miss;
endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare: a bimodal build (GHR_W=0) for BTB/PHT/flush/perf
// behaviour and a small gshare build (IDX_W=4, GHR_W=2) for history indexing.
module tb_bpu_gshare;
  logic cpu_clk = 1'b0;
  logic cpu_rstn = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int unsigned exp_br = 0;
  int unsigned exp_miss = 0;

  always #5 cpu_clk = ~cpu_clk;

  bpu_gshare_if bif ();
  bpu_gshare_if gif ();

  bpu_gshare #(.IDX_W(10), .TAG_W(8), .GHR_W(0), .CTR_INIT(2'b10)) u_dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .bus(bif.slave));

  bpu_gshare #(.IDX_W(4), .TAG_W(8), .GHR_W(2), .CTR_INIT(2'b10)) u_gdut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .bus(gif.slave));

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle();
    bif.bpu_clear = 0; bif.ex_valid1 = 0; bif.ex_valid2 = 0;
    bif.ex_is_bj_1 = 0; bif.ex_is_bj_2 = 0; bif.real_taken1 = 0; bif.real_taken2 = 0;
    bif.ex_pc_1 = 0; bif.ex_pc_2 = 0; bif.real_addr1 = 0; bif.real_addr2 = 0;
    bif.pred_addr1 = 0; bif.pred_addr2 = 0;
    gif.bpu_clear = 0; gif.ex_valid1 = 0; gif.ex_valid2 = 0;
    gif.ex_is_bj_1 = 0; gif.ex_is_bj_2 = 0; gif.real_taken1 = 0; gif.real_taken2 = 0;
    gif.ex_pc_1 = 0; gif.ex_pc_2 = 0; gif.real_addr1 = 0; gif.real_addr2 = 0;
    gif.pred_addr1 = 0; gif.pred_addr2 = 0;
  endtask

  task automatic drive1(input logic bj, input logic tk, input logic [31:0] pc,
                        input logic [31:0] ra, input logic [31:0] pa);
    bif.ex_valid1 = 1; bif.ex_is_bj_1 = bj; bif.real_taken1 = tk;
    bif.ex_pc_1 = pc; bif.real_addr1 = ra; bif.pred_addr1 = pa;
  endtask

  task automatic drive2(input logic bj, input logic tk, input logic [31:0] pc,
                        input logic [31:0] ra, input logic [31:0] pa);
    bif.ex_valid2 = 1; bif.ex_is_bj_2 = bj; bif.real_taken2 = tk;
    bif.ex_pc_2 = pc; bif.real_addr2 = ra; bif.pred_addr2 = pa;
  endtask

  task automatic test_reset();
    bif.if_pc = 32'h1C00_0000;
    #1;
    n_vec++; if (bif.pred_taken1 !== 1'b0) begin n_err++; $display("FAIL rst_t1 got %0b exp 0", bif.pred_taken1); end
    n_vec++; if (bif.pred_taken2 !== 1'b0) begin n_err++; $display("FAIL rst_t2 got %0b exp 0", bif.pred_taken2); end
    n_vec++; if (bif.pred_addr !== 32'h1C00_0008) begin n_err++; $display("FAIL rst_addr got %h exp 1c000008", bif.pred_addr); end
    n_vec++; if (bif.perf_br_cnt !== 32'd0) begin n_err++; $display("FAIL rst_br got %0d exp 0", bif.perf_br_cnt); end
    n_vec++; if (bif.perf_miss_cnt !== 32'd0) begin n_err++; $display("FAIL rst_miss got %0d exp 0", bif.perf_miss_cnt); end
    n_vec++; if (bif.bpu_flush !== 1'b0) begin n_err++; $display("FAIL rst_flush got %0b exp 0", bif.bpu_flush); end
    cpu_rstn = 1;
    tick();
    n_vec++; if (bif.pred_addr !== 32'h1C00_0008) begin n_err++; $display("FAIL rst_rel_addr got %h exp 1c000008", bif.pred_addr); end
  endtask

  task automatic test_alloc();
    drive1(1, 1, 32'h1C00_0010, 32'h1C00_0100, 32'h1C00_0018);
    #1;
    n_vec++; if (bif.bpu_flush !== 1'b1) begin n_err++; $display("FAIL alloc_flush got %0b exp 1", bif.bpu_flush); end
    tick(); idle(); exp_br++; exp_miss++;
    n_vec++; if (bif.perf_miss_cnt !== exp_miss) begin n_err++; $display("FAIL alloc_miss got %0d exp %0d", bif.perf_miss_cnt, exp_miss); end
    n_vec++; if (bif.perf_br_cnt !== exp_br) begin n_err++; $display("FAIL alloc_br got %0d exp %0d", bif.perf_br_cnt, exp_br); end
    bif.if_pc = 32'h1C00_0010; #1;
    n_vec++; if (bif.pred_taken1 !== 1'b1) begin n_err++; $display("FAIL alloc_t1 got %0b exp 1", bif.pred_taken1); end
    n_vec++; if (bif.pred_addr !== 32'h1C00_0100) begin n_err++; $display("FAIL alloc_addr got %h exp 1c000100", bif.pred_addr); end
    bif.if_pc = 32'h1C00_000C; #1;
    n_vec++; if (bif.pred_taken1 !== 1'b0) begin n_err++; $display("FAIL slot1_t1 got %0b exp 0", bif.pred_taken1); end
    n_vec++; if (bif.pred_taken2 !== 1'b1) begin n_err++; $display("FAIL slot1_t2 got %0b exp 1", bif.pred_taken2); end
    n_vec++; if (bif.pred_addr !== 32'h1C00_0100) begin n_err++; $display("FAIL slot1_addr got %h exp 1c000100", bif.pred_addr); end
  endtask

  task automatic test_counter();
    // directions applied to the 0x1C000010 entry (counter starts at 2) and taken1 expected after each
    logic dir [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    logic exp [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    for (int k = 0; k < 8; k++) begin
      if (dir[k]) drive1(1, 1, 32'h1C00_0010, 32'h1C00_0100, 32'h1C00_0100);
      else        drive1(1, 0, 32'h1C00_0010, 32'h1C00_0014, 32'h1C00_0014);
      tick(); idle(); exp_br++;
      bif.if_pc = 32'h1C00_0010; #1;
      n_vec++; if (bif.pred_taken1 !== exp[k]) begin n_err++; $display("FAIL ctr_step%0d got %0b exp %0b", k, bif.pred_taken1, exp[k]); end
      if (k == 1) begin
        bif.if_pc = 32'h1C00_000C; #1;
        n_vec++; if (bif.pred_taken2 !== 1'b0) begin n_err++; $display("FAIL ctr0_t2 got %0b exp 0", bif.pred_taken2); end
        n_vec++; if (bif.pred_addr !== 32'h1C00_0014) begin n_err++; $display("FAIL ctr0_addr got %h exp 1c000014", bif.pred_addr); end
      end
    end
    n_vec++; if (bif.perf_br_cnt !== exp_br) begin n_err++; $display("FAIL ctr_br got %0d exp %0d", bif.perf_br_cnt, exp_br); end
    n_vec++; if (bif.perf_miss_cnt !== exp_miss) begin n_err++; $display("FAIL ctr_miss got %0d exp %0d", bif.perf_miss_cnt, exp_miss); end
  endtask

  task automatic test_slot2_dead();
    drive1(1, 1, 32'h1C00_0010, 32'h1C00_0100, 32'h1C00_0100);
    drive2(1, 1, 32'h1C00_0200, 32'h1C00_0300, 32'h1C00_0204);
    #1;
    n_vec++; if (bif.bpu_flush !== 1'b0) begin n_err++; $display("FAIL dead_flush got %0b exp 0", bif.bpu_flush); end
    tick(); idle(); exp_br++;
    n_vec++; if (bif.perf_br_cnt !== exp_br) begin n_err++; $display("FAIL dead_br got %0d exp %0d", bif.perf_br_cnt, exp_br); end
    n_vec++; if (bif.perf_miss_cnt !== exp_miss) begin n_err++; $display("FAIL dead_miss got %0d exp %0d", bif.perf_miss_cnt, exp_miss); end
    bif.if_pc = 32'h1C00_0200; #1;
    n_vec++; if (bif.pred_taken1 !== 1'b0) begin n_err++; $display("FAIL dead_btb got %0b exp 0", bif.pred_taken1); end
    n_vec++; if (bif.pred_addr !== 32'h1C00_0208) begin n_err++; $display("FAIL dead_addr got %h exp 1c000208", bif.pred_addr); end
  endtask

  task automatic test_slot2_live();
    drive1(0, 0, 32'h1C00_0300, 32'h1C00_0304, 32'h1C00_0304);
    drive2(1, 1, 32'h1C00_0200, 32'h1C00_0300, 32'h1C00_0204);
    #1;
    n_vec++; if (bif.bpu_flush !== 1'b1) begin n_err++; $display("FAIL live_flush got %0b exp 1", bif.bpu_flush); end
    tick(); idle(); exp_br++; exp_miss++;
    n_vec++; if (bif.perf_br_cnt !== exp_br) begin n_err++; $display("FAIL live_br got %0d exp %0d", bif.perf_br_cnt, exp_br); end
    n_vec++; if (bif.perf_miss_cnt !== exp_miss) begin n_err++; $display("FAIL live_miss got %0d exp %0d", bif.perf_miss_cnt, exp_miss); end
    bif.if_pc = 32'h1C00_01FC; #1;
    n_vec++; if (bif.pred_taken2 !== 1'b1) begin n_err++; $display("FAIL live_t2 got %0b exp 1", bif.pred_taken2); end
    n_vec++; if (bif.pred_addr !== 32'h1C00_0300) begin n_err++; $display("FAIL live_addr got %h exp 1c000300", bif.pred_addr); end
  endtask

  task automatic test_err1();
    drive1(0, 0, 32'h1C00_0500, 32'h1C00_0504, 32'h1C00_0508);
    drive2(1, 1, 32'h1C00_0600, 32'h1C00_0700, 32'h1C00_0604);
    #1;
    n_vec++; if (bif.bpu_flush !== 1'b1) begin n_err++; $display("FAIL err1_flush got %0b exp 1", bif.bpu_flush); end
    tick(); idle(); exp_miss++;
    n_vec++; if (bif.perf_br_cnt !== exp_br) begin n_err++; $display("FAIL err1_br got %0d exp %0d", bif.perf_br_cnt, exp_br); end
    n_vec++; if (bif.perf_miss_cnt !== exp_miss) begin n_err++; $display("FAIL err1_miss got %0d exp %0d", bif.perf_miss_cnt, exp_miss); end
    bif.if_pc = 32'h1C00_0600; #1;
    n_vec++; if (bif.pred_addr !== 32'h1C00_0608) begin n_err++; $display("FAIL err1_btb got %h exp 1c000608", bif.pred_addr); end
  endtask

  task automatic test_alias();
    drive1(1, 1, 32'h1C00_0400, 32'h1C00_0500, 32'h1C00_0500);
    drive2(1, 1, 32'h2C00_0400, 32'h2C00_0600, 32'h2C00_0600);
    tick(); idle(); exp_br++;
    bif.if_pc = 32'h1C00_0400; #1;
    n_vec++; if (bif.pred_addr !== 32'h1C00_0500) begin n_err++; $display("FAIL alias_a got %h exp 1c000500", bif.pred_addr); end
    bif.if_pc = 32'h2C00_0400; #1;
    n_vec++; if (bif.pred_taken1 !== 1'b0) begin n_err++; $display("FAIL alias_b_t1 got %0b exp 0", bif.pred_taken1); end
    n_vec++; if (bif.pred_addr !== 32'h2C00_0408) begin n_err++; $display("FAIL alias_b got %h exp 2c000408", bif.pred_addr); end
    drive1(1, 1, 32'h2C00_0400, 32'h2C00_0600, 32'h2C00_0408);
    tick(); idle(); exp_br++; exp_miss++;
    #1;
    n_vec++; if (bif.pred_addr !== 32'h2C00_0600) begin n_err++; $display("FAIL repl_b got %h exp 2c000600", bif.pred_addr); end
    bif.if_pc = 32'h1C00_0400; #1;
    n_vec++; if (bif.pred_addr !== 32'h1C00_0408) begin n_err++; $display("FAIL repl_a got %h exp 1c000408", bif.pred_addr); end
  endtask

  task automatic test_clear();
    bif.bpu_clear = 1;
    drive1(1, 1, 32'h1C00_0800, 32'h1C00_0900, 32'h1C00_0808);
    #1;
    n_vec++; if (bif.bpu_flush !== 1'b1) begin n_err++; $display("FAIL clr_flush got %0b exp 1", bif.bpu_flush); end
    tick(); idle(); exp_br++; exp_miss++;
    n_vec++; if (bif.perf_br_cnt !== exp_br) begin n_err++; $display("FAIL clr_br got %0d exp %0d", bif.perf_br_cnt, exp_br); end
    n_vec++; if (bif.perf_miss_cnt !== exp_miss) begin n_err++; $display("FAIL clr_miss got %0d exp %0d", bif.perf_miss_cnt, exp_miss); end
    bif.if_pc = 32'h1C00_0010; #1;
    n_vec++; if (bif.pred_addr !== 32'h1C00_0018) begin n_err++; $display("FAIL clr_e0 got %h exp 1c000018", bif.pred_addr); end
    bif.if_pc = 32'h1C00_01FC; #1;
    n_vec++; if (bif.pred_addr !== 32'h1C00_0204) begin n_err++; $display("FAIL clr_e1 got %h exp 1c000204", bif.pred_addr); end
    bif.if_pc = 32'h1C00_0800; #1;
    n_vec++; if (bif.pred_addr !== 32'h1C00_0808) begin n_err++; $display("FAIL clr_alloc got %h exp 1c000808", bif.pred_addr); end
  endtask

  task automatic test_async_reset();
    drive1(1, 1, 32'h1C00_0010, 32'h1C00_0100, 32'h1C00_0018);
    tick(); idle(); exp_br++; exp_miss++;
    bif.if_pc = 32'h1C00_0010; #1;
    n_vec++; if (bif.pred_taken1 !== 1'b1) begin n_err++; $display("FAIL arst_pre got %0b exp 1", bif.pred_taken1); end
    drive1(1, 1, 32'h1C00_0900, 32'h1C00_0A00, 32'h1C00_0908);
    #1;
    cpu_rstn = 0;
    #1;
    n_vec++; if (bif.pred_taken1 !== 1'b0) begin n_err++; $display("FAIL arst_t1 got %0b exp 0", bif.pred_taken1); end
    n_vec++; if (bif.pred_addr !== 32'h1C00_0018) begin n_err++; $display("FAIL arst_addr got %h exp 1c000018", bif.pred_addr); end
    n_vec++; if (bif.perf_br_cnt !== 32'd0) begin n_err++; $display("FAIL arst_br got %0d exp 0", bif.perf_br_cnt); end
    n_vec++; if (bif.perf_miss_cnt !== 32'd0) begin n_err++; $display("FAIL arst_miss got %0d exp 0", bif.perf_miss_cnt); end
    tick(); idle(); exp_br = 0; exp_miss = 0;
    cpu_rstn = 1;
    tick();
    bif.if_pc = 32'h1C00_0900; #1;
    n_vec++; if (bif.pred_addr !== 32'h1C00_0908) begin n_err++; $display("FAIL arst_pend got %h exp 1c000908", bif.pred_addr); end
    n_vec++; if (bif.perf_br_cnt !== 32'd0) begin n_err++; $display("FAIL arst_br2 got %0d exp 0", bif.perf_br_cnt); end
  endtask

  task automatic test_ghr();
    // idx(pc)=pc[5:2]^pc[9:6]; P=0x1C000010 -> 4, Q=0x1C000080 -> 2, R=0x1C000040 -> 1
    gif.ex_valid1 = 1; gif.ex_is_bj_1 = 1; gif.real_taken1 = 1;
    gif.ex_pc_1 = 32'h1C00_0010; gif.real_addr1 = 32'h1C00_0400; gif.pred_addr1 = 32'h1C00_0400;
    tick();
    gif.real_taken1 = 0; gif.real_addr1 = 32'h1C00_0014; gif.pred_addr1 = 32'h1C00_0014;
    tick(); idle();
    gif.if_pc = 32'h1C00_0010; #1;
    n_vec++; if (gif.pred_taken1 !== 1'b1) begin n_err++; $display("FAIL ghr_t1 got %0b exp 1", gif.pred_taken1); end
    n_vec++; if (gif.pred_addr !== 32'h1C00_0400) begin n_err++; $display("FAIL ghr_addr got %h exp 1c000400", gif.pred_addr); end
    gif.ex_valid1 = 1; gif.ex_is_bj_1 = 1; gif.real_taken1 = 0;
    gif.ex_pc_1 = 32'h1C00_0080; gif.real_addr1 = 32'h1C00_0084; gif.pred_addr1 = 32'h1C00_0084;
    gif.ex_valid2 = 1; gif.ex_is_bj_2 = 1; gif.real_taken2 = 1;
    gif.ex_pc_2 = 32'h1C00_0040; gif.real_addr2 = 32'h1C00_0800; gif.pred_addr2 = 32'h1C00_0800;
    tick(); idle();
    #1;
    n_vec++; if (gif.pred_taken1 !== 1'b0) begin n_err++; $display("FAIL ghr2_t1 got %0b exp 0", gif.pred_taken1); end
    n_vec++; if (gif.pred_addr !== 32'h1C00_0018) begin n_err++; $display("FAIL ghr2_addr got %h exp 1c000018", gif.pred_addr); end
    gif.if_pc = 32'h1C00_0040; #1;
    n_vec++; if (gif.pred_addr !== 32'h1C00_0800) begin n_err++; $display("FAIL ghr_slot2_alloc got %h exp 1c000800", gif.pred_addr); end
  endtask

  initial begin
    idle();
    bif.if_pc = 32'h1C00_0000;
    gif.if_pc = 32'h1C00_0000;
    cpu_rstn = 0;
    repeat (2) @(posedge cpu_clk);
    #1;
    test_reset();
    test_alloc();
    test_counter();
    test_slot2_dead();
    test_slot2_live();
    test_err1();
    test_alias();
    test_clear();
    test_async_reset();
    test_ghr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
